// File: rtl/fwft_fifo_prog.sv
// First-word-fall-through FIFO with arbitrary depth, occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow flags.
module fwft_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 81,
  parameter int AF_THRESH  = 76,
  parameter int AE_THRESH  = 4,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2) begin : g_bad_depth
    $error("fwft_fifo_prog: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fwft_fifo_prog: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("fwft_fifo_prog: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW-1:0]         wr_ptr_next, rd_ptr_next;
  logic [CW-1:0]         count_next;
  logic                  push, pop;

  // Handshakes use the registered ready/valid, so out_ready never reaches in_ready combinationally.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign out_data = mem[rd_ptr];

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    count_next  = count;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (flush) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) begin
        wr_ptr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr_next = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; out_data is only meaningful while
  // out_valid=1, and resetting a RAM would prevent it mapping onto memory primitives.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      count        <= count_next;
      in_ready     <= (count_next != CW'(DEPTH));
      out_valid    <= (count_next != '0);
      almost_full  <= (count_next >= CW'(AF_THRESH));
      almost_empty <= (count_next <= CW'(AE_THRESH));
      // Error flags are sticky and survive flush; only reset clears them.
      if (in_valid && !in_ready && count == CW'(DEPTH)) begin
        overflow <= 1'b1;
      end
      if (out_ready && !out_valid) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwft_fifo_prog.sv
// Directed bench for fwft_fifo_prog: a DEPTH=5 instance for fill/drain/wrap/flush/error
// scenarios and a DEPTH=81 instance for randomised-handshake ordering.
module tb_fwft_fifo_prog;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // DEPTH=5 instance: AF_THRESH=4, AE_THRESH=1
  logic       flush5, in_valid5, in_ready5, out_valid5, out_ready5;
  logic       af5, ae5, ovf5, unf5;
  logic [7:0] in_data5, out_data5;
  logic [2:0] count5;

  fwft_fifo_prog #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_dut5 (
    .clk(clk), .reset(reset), .flush(flush5),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .count(count5), .almost_full(af5), .almost_empty(ae5),
    .overflow(ovf5), .underflow(unf5)
  );

  // DEPTH=81 instance with default parameters
  logic       flush81, in_valid81, in_ready81, out_valid81, out_ready81;
  logic       af81, ae81, ovf81, unf81;
  logic [7:0] in_data81, out_data81;
  logic [6:0] count81;

  fwft_fifo_prog u_dut81 (
    .clk(clk), .reset(reset), .flush(flush81),
    .in_valid(in_valid81), .in_ready(in_ready81), .in_data(in_data81),
    .out_valid(out_valid81), .out_ready(out_ready81), .out_data(out_data81),
    .count(count81), .almost_full(af81), .almost_empty(ae81),
    .overflow(ovf81), .underflow(unf81)
  );

  // Outputs are sampled and inputs driven 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_vec++; if (count5 !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count5); end
    n_vec++; if (in_ready5 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready5); end
    n_vec++; if (out_valid5 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid5); end
    n_vec++; if (af5 !== 1'b0) begin n_err++; $display("FAIL reset_almost_full: got %b want 0", af5); end
    n_vec++; if (ae5 !== 1'b1) begin n_err++; $display("FAIL reset_almost_empty: got %b want 1", ae5); end
    n_vec++; if ({ovf5, unf5} !== 2'b00) begin n_err++; $display("FAIL reset_errors: got %b want 00", {ovf5, unf5}); end
    n_vec++; if (count81 !== 7'd0 || in_ready81 !== 1'b1 || out_valid81 !== 1'b0 || ae81 !== 1'b1 || af81 !== 1'b0) begin
      n_err++; $display("FAIL reset_dut81: count %0d in_ready %b out_valid %b ae %b af %b", count81, in_ready81, out_valid81, ae81, af81);
    end
  endtask

  task automatic test_fill();
    out_ready5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid5 = 1'b1;
      in_data5  = 8'(i);
      tick();
      n_vec++; if (count5 !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count5, i + 1); end
      n_vec++; if (in_ready5 !== (i < 4)) begin n_err++; $display("FAIL fill_in_ready[%0d]: got %b want %b", i, in_ready5, i < 4); end
      n_vec++; if (af5 !== (i + 1 >= 4)) begin n_err++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, af5, i + 1 >= 4); end
      n_vec++; if (ae5 !== (i + 1 <= 1)) begin n_err++; $display("FAIL fill_almost_empty[%0d]: got %b want %b", i, ae5, i + 1 <= 1); end
      n_vec++; if (out_valid5 !== 1'b1 || out_data5 !== 8'd0) begin
        n_err++; $display("FAIL fill_head[%0d]: got valid %b data %0d want valid 1 data 0", i, out_valid5, out_data5);
      end
    end
    in_valid5 = 1'b0;
  endtask

  task automatic test_overflow();
    n_vec++; if (ovf5 !== 1'b0) begin n_err++; $display("FAIL overflow_before: got %b want 0", ovf5); end
    in_valid5 = 1'b1;
    in_data5  = 8'd77;
    tick();
    in_valid5 = 1'b0;
    n_vec++; if (ovf5 !== 1'b1) begin n_err++; $display("FAIL overflow_set: got %b want 1", ovf5); end
    n_vec++; if (count5 !== 3'd5 || out_data5 !== 8'd0) begin
      n_err++; $display("FAIL overflow_no_effect: count %0d head %0d want 5 and 0", count5, out_data5);
    end
    tick();
    n_vec++; if (ovf5 !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %b want 1", ovf5); end
  endtask

  // At full, a simultaneous push attempt is blocked while the pop proceeds.
  task automatic test_full_pop();
    in_valid5  = 1'b1;
    in_data5   = 8'd50;
    out_ready5 = 1'b1;
    tick();
    in_valid5  = 1'b0;
    out_ready5 = 1'b0;
    n_vec++; if (count5 !== 3'd4) begin n_err++; $display("FAIL full_pop_count: got %0d want 4", count5); end
    n_vec++; if (in_ready5 !== 1'b1) begin n_err++; $display("FAIL full_pop_in_ready: got %b want 1", in_ready5); end
    n_vec++; if (out_data5 !== 8'd1) begin n_err++; $display("FAIL full_pop_head: got %0d want 1", out_data5); end
  endtask

  task automatic test_drain();
    out_ready5 = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_vec++; if (out_valid5 !== 1'b1 || out_data5 !== 8'(i)) begin
        n_err++; $display("FAIL drain_data[%0d]: got valid %b data %0d want valid 1 data %0d", i, out_valid5, out_data5, i);
      end
      tick();
      n_vec++; if (count5 !== 3'(4 - i)) begin n_err++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count5, 4 - i); end
    end
    n_vec++; if (out_valid5 !== 1'b0 || in_ready5 !== 1'b1 || ae5 !== 1'b1) begin
      n_err++; $display("FAIL drain_empty: valid %b in_ready %b ae %b want 0 1 1", out_valid5, in_ready5, ae5);
    end
    n_vec++; if (unf5 !== 1'b0) begin n_err++; $display("FAIL underflow_before: got %b want 0", unf5); end
    tick();
    out_ready5 = 1'b0;
    n_vec++; if (unf5 !== 1'b1) begin n_err++; $display("FAIL underflow_set: got %b want 1", unf5); end
    n_vec++; if (count5 !== 3'd0) begin n_err++; $display("FAIL underflow_no_effect: count %0d want 0", count5); end
  endtask

  task automatic test_wrap();
    in_valid5 = 1'b1;
    in_data5  = 8'd100;
    tick();
    n_vec++; if (count5 !== 3'd1 || out_data5 !== 8'd100) begin
      n_err++; $display("FAIL wrap_prime: count %0d head %0d want 1 and 100", count5, out_data5);
    end
    out_ready5 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_data5 = 8'(101 + k);
      n_vec++; if (out_data5 !== 8'(100 + k) || out_valid5 !== 1'b1) begin
        n_err++; $display("FAIL wrap_data[%0d]: got %0d valid %b want %0d valid 1", k, out_data5, out_valid5, 100 + k);
      end
      tick();
      n_vec++; if (count5 !== 3'd1) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want 1", k, count5); end
    end
    in_valid5 = 1'b0;
    n_vec++; if (out_data5 !== 8'd112) begin n_err++; $display("FAIL wrap_last: got %0d want 112", out_data5); end
    tick();
    out_ready5 = 1'b0;
    n_vec++; if (count5 !== 3'd0 || out_valid5 !== 1'b0) begin
      n_err++; $display("FAIL wrap_drained: count %0d valid %b want 0 0", count5, out_valid5);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid5 = 1'b1;
      in_data5  = 8'(20 + i);
      tick();
    end
    n_vec++; if (count5 !== 3'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d want 3", count5); end
    flush5     = 1'b1;
    in_data5   = 8'd99;
    out_ready5 = 1'b1;
    tick();
    flush5     = 1'b0;
    in_valid5  = 1'b0;
    out_ready5 = 1'b0;
    n_vec++; if (count5 !== 3'd0 || out_valid5 !== 1'b0 || in_ready5 !== 1'b1) begin
      n_err++; $display("FAIL flush_state: count %0d valid %b in_ready %b want 0 0 1", count5, out_valid5, in_ready5);
    end
    n_vec++; if (ae5 !== 1'b1 || af5 !== 1'b0) begin n_err++; $display("FAIL flush_flags: ae %b af %b want 1 0", ae5, af5); end
    n_vec++; if ({ovf5, unf5} !== 2'b11) begin n_err++; $display("FAIL flush_keeps_errors: got %b want 11", {ovf5, unf5}); end
    in_valid5 = 1'b1;
    in_data5  = 8'd30;
    tick();
    in_valid5 = 1'b0;
    n_vec++; if (count5 !== 3'd1 || out_data5 !== 8'd30) begin
      n_err++; $display("FAIL flush_next_word: count %0d head %0d want 1 and 30", count5, out_data5);
    end
  endtask

  task automatic test_reset_midstream();
    in_valid5 = 1'b1;
    in_data5  = 8'd40;
    tick();
    in_valid5 = 1'b0;
    reset  = 1'b1;
    flush5 = 1'b1;
    tick();
    reset  = 1'b0;
    flush5 = 1'b0;
    n_vec++; if (count5 !== 3'd0 || out_valid5 !== 1'b0 || in_ready5 !== 1'b1 || ae5 !== 1'b1) begin
      n_err++; $display("FAIL midreset_state: count %0d valid %b in_ready %b ae %b want 0 0 1 1", count5, out_valid5, in_ready5, ae5);
    end
    n_vec++; if ({ovf5, unf5} !== 2'b00) begin n_err++; $display("FAIL midreset_errors: got %b want 00", {ovf5, unf5}); end
  endtask

  // Random handshakes on the DEPTH=81 instance; the model tracks expected head and occupancy.
  task automatic test_random_order();
    int next_in  = 0;
    int next_out = 0;
    int occ      = 0;
    int cycles   = 0;
    bit push, pop;
    while (next_out < 81 && cycles < 5000) begin
      in_valid81  = (next_in < 81) && ($urandom_range(1) == 1);
      in_data81   = 8'(next_in);
      out_ready81 = ($urandom_range(1) == 1);
      push = in_valid81 && in_ready81;
      pop  = out_valid81 && out_ready81;
      if (pop) begin
        n_vec++; if (out_data81 !== 8'(next_out)) begin
          n_err++; $display("FAIL order81[%0d]: got %0d want %0d", next_out, out_data81, next_out);
        end
        next_out++;
      end
      if (push) next_in++;
      occ = occ + int'(push) - int'(pop);
      tick();
      cycles++;
      n_vec++; if (count81 !== 7'(occ) || count81 > 7'd81) begin
        n_err++; $display("FAIL count81 cycle %0d: got %0d want %0d", cycles, count81, occ);
      end
    end
    in_valid81  = 1'b0;
    out_ready81 = 1'b0;
    n_vec++; if (next_out !== 81) begin n_err++; $display("FAIL order81_timeout: got %0d words want 81", next_out); end
  endtask

  initial begin
    reset = 1'b1;
    flush5 = 1'b0; in_valid5 = 1'b0; out_ready5 = 1'b0; in_data5 = '0;
    flush81 = 1'b0; in_valid81 = 1'b0; out_ready81 = 1'b0; in_data81 = '0;
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_full_pop();
    test_drain();
    test_wrap();
    test_flush();
    test_reset_midstream();
    test_random_order();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
